// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash navigator between the boot copier (port 0) and the CPU (port 1).
// Optional per-phase watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_arbiter #(
   parameter logic [23:0] BASE_ADDR = 24'h500000
`ifdef FLASH_ARB_TIMEOUT_EN
   ,
   parameter logic [19:0] TIMEOUT   = 20'd1000000
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [23:0] addr0,
   input  logic [23:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata,
   output logic        err,
   output logic        nav_enable,
   output logic        nav_ren,
   output logic        nav_wen,
   output logic [23:0] nav_addr,
   output logic [31:0] nav_wdata,
   input  logic        nav_ready,
   input  logic [31:0] nav_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

   state_t state;
   logic   rr_last;   // port granted most recently
   logic   winner;    // port owning the current transaction
   logic   win_sel;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      win_sel = 1'b0;
      if (req0 && req1)
         win_sel = ~rr_last;
      else
         win_sel = req1;
   end

`ifdef FLASH_ARB_TIMEOUT_EN
   logic        err_q;
   logic [19:0] tmo_cnt;
   logic        tmo_hit;

   assign tmo_hit = (tmo_cnt == TIMEOUT);
   assign err     = err_q;
`else
   assign err = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rr_last    <= 1'b1;
         winner     <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata      <= 32'h0;
         nav_enable <= 1'b0;
         nav_ren    <= 1'b0;
         nav_wen    <= 1'b0;
         nav_addr   <= 24'h0;
         nav_wdata  <= 32'h0;
`ifdef FLASH_ARB_TIMEOUT_EN
         err_q      <= 1'b0;
         tmo_cnt    <= 20'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if ((req0 || req1) && nav_ready) begin
                  winner     <= win_sel;
                  rr_last    <= win_sel;
                  nav_enable <= 1'b1;
                  nav_ren    <= win_sel ? ~we1 : ~we0;
                  nav_wen    <= win_sel ? we1 : we0;
                  nav_addr   <= (win_sel ? addr1 : addr0) + BASE_ADDR;
                  nav_wdata  <= win_sel ? wdata1 : wdata0;
                  state      <= ISSUE;
`ifdef FLASH_ARB_TIMEOUT_EN
                  tmo_cnt    <= 20'd0;
`endif
               end
            end

            ISSUE: begin
`ifdef FLASH_ARB_TIMEOUT_EN
               if (tmo_hit) begin
                  nav_enable <= 1'b0;
                  nav_ren    <= 1'b0;
                  nav_wen    <= 1'b0;
                  rdata      <= 32'hdeadbeaf;
                  err_q      <= 1'b1;
                  ack0       <= ~winner;
                  ack1       <= winner;
                  state      <= DONE;
               end else if (!nav_ready) begin
                  tmo_cnt <= 20'd0;
                  state   <= BUSY;
               end else begin
                  tmo_cnt <= tmo_cnt + 20'd1;
               end
`else
               if (!nav_ready)
                  state <= BUSY;
`endif
            end

            BUSY: begin
`ifdef FLASH_ARB_TIMEOUT_EN
               if (tmo_hit) begin
                  nav_enable <= 1'b0;
                  nav_ren    <= 1'b0;
                  nav_wen    <= 1'b0;
                  rdata      <= 32'hdeadbeaf;
                  err_q      <= 1'b1;
                  ack0       <= ~winner;
                  ack1       <= winner;
                  state      <= DONE;
               end else if (nav_ready) begin
                  if (nav_ren)
                     rdata <= nav_rdata;
                  nav_enable <= 1'b0;
                  nav_ren    <= 1'b0;
                  nav_wen    <= 1'b0;
                  err_q      <= 1'b0;
                  ack0       <= ~winner;
                  ack1       <= winner;
                  state      <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 20'd1;
               end
`else
               if (nav_ready) begin
                  if (nav_ren)
                     rdata <= nav_rdata;
                  nav_enable <= 1'b0;
                  nav_ren    <= 1'b0;
                  nav_wen    <= 1'b0;
                  ack0       <= ~winner;
                  ack1       <= winner;
                  state      <= DONE;
               end
`endif
            end

            DONE: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
               err_q <= 1'b0;
`endif
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
